merge_comparator: RTL and testbench

//  Merge-stage selector of the hardware sorter: compares the head words of two
//  pre-sorted streams A and B and forwards the smaller one (ascending merge).

---
 rtl/merge_cmp_pkg.sv | 14 +
 rtl/merge_cmp_select.sv | 32 +++
 rtl/merge_comparator.sv | 62 ++++++
 tb/tb_merge_comparator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/merge_cmp_pkg.sv
// rtl/merge_cmp_pkg.sv - shared word type and selection encoding for the merge comparator
package merge_cmp_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_t;

endpackage

// File: rtl/merge_cmp_select.sv
// rtl/merge_cmp_select.sv - head-word compare and stream choice; MERGE_CMP_DESC_EN selects descending order
module merge_cmp_select
    import merge_cmp_pkg::*;
(
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld,
    output sel_t              sel
);

    logic a_first;

    // Ties go to A in both directions so equal keys keep their stream order.
`ifdef MERGE_CMP_DESC_EN
    assign a_first = (a_in >= b_in);
`else
    assign a_first = (a_in <= b_in);
`endif

    always_comb begin
        sel = SEL_NONE;
        if (a_vld && b_vld) begin
            sel = a_first ? SEL_A : SEL_B;
        end else if (a_vld) begin
            sel = SEL_A;
        end else if (b_vld) begin
            sel = SEL_B;
        end
    end

endmodule

// File: rtl/merge_comparator.sv
// rtl/merge_comparator.sv - merge-stage selector: pops the preferred head word and registers it downstream
// Build option: MERGE_CMP_DESC_EN (descending merge, handled in merge_cmp_select)
module merge_comparator
    import merge_cmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld,
    input  logic              ena,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] data_out,
    output logic              pop_a,
    output logic              pop_b,
    output logic              valid
);

    sel_t sel;
    logic accept;
    logic take_a;
    logic take_b;

    merge_cmp_select u_select (
        .a_in  (a_in),
        .a_vld (a_vld),
        .b_in  (b_in),
        .b_vld (b_vld),
        .sel   (sel)
    );

    // The output register may load when it is empty or its word leaves this cycle.
    assign accept = ena & (~valid | out_rdy);

    // rst_n gates the pops so nothing is dequeued while the register is held clear.
    assign take_a = rst_n & accept & (sel == SEL_A);
    assign take_b = rst_n & accept & (sel == SEL_B);
    assign pop_a  = take_a;
    assign pop_b  = take_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (accept) begin
            if (take_a) begin
                data_out <= a_in;
                valid    <= 1'b1;
            end else if (take_b) begin
                data_out <= b_in;
                valid    <= 1'b1;
            end else begin
                valid    <= 1'b0;
            end
        end else if (!ena && out_rdy) begin
            // Disabled but downstream took the word: retire it without refilling.
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_merge_comparator.sv
// tb/tb_merge_comparator.sv - directed-vector bench for merge_comparator
module tb_merge_comparator;
    import merge_cmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    word_t       a_in, b_in, data_out;
    logic        a_vld, b_vld, ena, out_rdy;
    logic        pop_a, pop_b, valid;

    int n_vec = 0;
    int n_err = 0;

`ifdef MERGE_CMP_DESC_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    always #5 clk = ~clk;

    merge_comparator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_in     (a_in),
        .a_vld    (a_vld),
        .b_in     (b_in),
        .b_vld    (b_vld),
        .ena      (ena),
        .out_rdy  (out_rdy),
        .data_out (data_out),
        .pop_a    (pop_a),
        .pop_b    (pop_b),
        .valid    (valid)
    );

    typedef struct packed {
        word_t a;
        logic  av;
        word_t b;
        logic  bv;
        logic  asc_pa;
        word_t asc_d;
        logic  desc_pa;
        word_t desc_d;
        logic  exp_v;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC] = '{
        '{32'd3524,       1'b1, 32'd242,        1'b1, 1'b0, 32'd242,        1'b1, 32'd3524,       1'b1},
        '{32'd241,        1'b1, 32'd242,        1'b1, 1'b1, 32'd241,        1'b0, 32'd242,        1'b1},
        '{32'd3532,       1'b1, 32'd39139,      1'b1, 1'b1, 32'd3532,       1'b0, 32'd39139,      1'b1},
        '{32'd3532,       1'b1, 32'd234,        1'b1, 1'b0, 32'd234,        1'b1, 32'd3532,       1'b1},
        '{32'd500,        1'b1, 32'd500,        1'b1, 1'b1, 32'd500,        1'b1, 32'd500,        1'b1},
        '{32'd7,          1'b1, 32'd999,        1'b0, 1'b1, 32'd7,          1'b1, 32'd7,          1'b1},
        '{32'd123,        1'b0, 32'd456,        1'b0, 1'b0, 32'd7,          1'b0, 32'd7,          1'b0},
        '{32'hFFFF_FFFF,  1'b1, 32'd1,          1'b1, 1'b0, 32'd1,          1'b1, 32'hFFFF_FFFF,  1'b1},
        '{32'h8000_0000,  1'b1, 32'h7FFF_FFFF,  1'b1, 1'b0, 32'h7FFF_FFFF,  1'b1, 32'h8000_0000,  1'b1},
        '{32'd1,          1'b0, 32'd99,         1'b1, 1'b0, 32'd99,         1'b0, 32'd99,         1'b1},
        '{32'd241,        1'b1, 32'd3532,       1'b1, 1'b1, 32'd241,        1'b0, 32'd3532,       1'b1}
    };

    task automatic drive(input word_t a, input logic av, input word_t b, input logic bv,
                         input logic en, input logic rdy);
        @(negedge clk);
        a_in    = a;
        a_vld   = av;
        b_in    = b;
        b_vld   = bv;
        ena     = en;
        out_rdy = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in = 32'd11; b_in = 32'd22; a_vld = 1'b1; b_vld = 1'b1; ena = 1'b1; out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (data_out !== 32'd0 || valid !== 1'b0 || pop_a !== 1'b0 || pop_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset: data_out=%0d valid=%b pop_a=%b pop_b=%b, required 0/0/0/0",
                     data_out, valid, pop_a, pop_b);
        end
        ena = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_disabled();
        for (int i = 0; i < 10; i++) begin
            drive(32'd3524, 1'b1, 32'd242, 1'b1, 1'b0, 1'b1);
            n_vec++;
            if (pop_a !== 1'b0 || pop_b !== 1'b0 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL disabled[%0d]: pop_a=%b pop_b=%b valid=%b, required 0/0/0",
                         i, pop_a, pop_b, valid);
            end
        end
    endtask

    task automatic test_merge();
        for (int i = 0; i < NVEC; i++) begin
            logic  e_pa, e_pb;
            word_t e_d;
            e_pa = DESC ? vecs[i].desc_pa : vecs[i].asc_pa;
            e_pb = vecs[i].exp_v & ~e_pa;
            e_d  = DESC ? vecs[i].desc_d : vecs[i].asc_d;
            drive(vecs[i].a, vecs[i].av, vecs[i].b, vecs[i].bv, 1'b1, 1'b1);
            n_vec++;
            if (pop_a !== e_pa || pop_b !== e_pb) begin
                n_err++;
                $display("FAIL merge_pop[%0d]: pop_a=%b pop_b=%b, required %b/%b",
                         i, pop_a, pop_b, e_pa, e_pb);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (data_out !== e_d || valid !== vecs[i].exp_v) begin
                n_err++;
                $display("FAIL merge_out[%0d]: data_out=%0h valid=%b, required %0h/%b",
                         i, data_out, valid, e_d, vecs[i].exp_v);
            end
        end
    endtask

    task automatic test_stall();
        drive(32'd10, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(32'd5, 1'b1, 32'd6, 1'b1, 1'b1, 1'b0);
            n_vec++;
            if (pop_a !== 1'b0 || pop_b !== 1'b0 || data_out !== 32'd10 || valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall[%0d]: pop_a=%b pop_b=%b data_out=%0d valid=%b, required 0/0/10/1",
                         i, pop_a, pop_b, data_out, valid);
            end
        end
        drive(32'd5, 1'b1, 32'd6, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (pop_a !== !DESC || pop_b !== DESC) begin
            n_err++;
            $display("FAIL stall_resume_pop: pop_a=%b pop_b=%b, required %b/%b",
                     pop_a, pop_b, !DESC, DESC);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (data_out !== (DESC ? 32'd6 : 32'd5) || valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_resume_out: data_out=%0d valid=%b, required %0d/1",
                     data_out, valid, DESC ? 6 : 5);
        end
    endtask

    task automatic test_ena_off();
        drive(32'd77, 1'b1, 32'd88, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (pop_a !== 1'b0 || pop_b !== 1'b0) begin
            n_err++;
            $display("FAIL ena_off_hold_pop: pop_a=%b pop_b=%b, required 0/0", pop_a, pop_b);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (valid !== 1'b1 || data_out !== (DESC ? 32'd6 : 32'd5)) begin
            n_err++;
            $display("FAIL ena_off_hold: data_out=%0d valid=%b, required %0d/1",
                     data_out, valid, DESC ? 6 : 5);
        end
        drive(32'd77, 1'b1, 32'd88, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (pop_a !== 1'b0 || pop_b !== 1'b0) begin
            n_err++;
            $display("FAIL ena_off_consume_pop: pop_a=%b pop_b=%b, required 0/0", pop_a, pop_b);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (valid !== 1'b0 || data_out !== (DESC ? 32'd6 : 32'd5)) begin
            n_err++;
            $display("FAIL ena_off_consume: data_out=%0d valid=%b, required %0d/0",
                     data_out, valid, DESC ? 6 : 5);
        end
    endtask

    task automatic test_async_reset();
        drive(32'd321, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if (valid !== 1'b1 || data_out !== 32'd321) begin
            n_err++;
            $display("FAIL pre_reset_load: data_out=%0d valid=%b, required 321/1", data_out, valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (data_out !== 32'd0 || valid !== 1'b0 || pop_a !== 1'b0 || pop_b !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: data_out=%0d valid=%b pop_a=%b pop_b=%b, required 0/0/0/0",
                     data_out, valid, pop_a, pop_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_merge();
        test_stall();
        test_ena_off();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
